rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Purpose:
//   Two requesters share one synchronous ROM. Each requester asks for a burst
//   of L = len+1 consecutive words starting at a given address. The arbiter
//   accepts one burst at a time and drives the ROM address one word per
//   cycle. Ties go to the requester that was not served last. Returned
//   data is tagged with a per-requester valid strobe.
//
// Ports:
//   clk              system clock, all state updates on its rising edge
//   rst              synchronous, active-high reset
//   req0/req1        burst request, held high until the matching gnt is seen
//   addr0/addr1      burst start address (sampled only at acceptance)
//   len0/len1        burst length minus one (sampled only at acceptance)
//   gnt0/gnt1        one-cycle pulse, burst accepted
//   vld0/vld1        rd_data belongs to this requester in the current cycle
//   rom_addr         registered ROM address
//   rom_data         ROM output, valid one cycle after rom_addr
//   rd_data          shared read data (straight copy of rom_data)
//   busy             high whenever a burst is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module rom_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [LW-1:0] len0,
  output logic          gnt0,
  output logic          vld0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len1,
  output logic          gnt1,
  output logic          vld1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] rd_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [LW-1:0] count_q, count_d;
  // Last-served requester; while a burst runs it also names the owner.
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic          sel;

  always_comb begin
    // Requester picked if an acceptance happens this cycle: on a tie the
    // one not served last wins, otherwise whichever is asking.
    sel        = (req0 && req1) ? ~last_q : req1;

    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    count_d    = count_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    vld0_d     = 1'b0;
    vld1_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          rom_addr_d = sel ? addr1 : addr0;
          count_d    = sel ? len1 : len0;
          last_d     = sel;
          gnt0_d     = ~sel;
          gnt1_d     = sel;
          state_d    = READ;
        end
      end

      READ: begin
        // An address is on the ROM this cycle, so its word comes back next
        // cycle: the valid strobe is simply READ delayed by one.
        vld0_d = ~last_q;
        vld1_d = last_q;
        if (count_q != '0) begin
          rom_addr_d = rom_addr_q + AW'(1);  // wraps modulo 2^AW
          count_d    = count_q - LW'(1);
        end else begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Last data word is returned in this cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- register stage: FSM state, address counter and strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      count_q    <= '0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign vld0     = vld0_q;
  assign vld1     = vld1_q;
  assign rom_addr = rom_addr_q;
  assign rd_data  = rom_data;
  assign busy     = (state_q != IDLE);

endmodule
